// File: rtl/sysctrl_pkg.sv
// Shared definitions for the board clock/reset controller: FSM state codes,
// trap handling modes, trap counter width and its saturating increment.
package sysctrl_pkg;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam int TRAP_MODE_HALT    = 0;
    localparam int TRAP_MODE_RESTART = 1;

    localparam int TRAP_CNT_W = 8;

    // Saturates at all-ones so a runaway trap loop cannot wrap the count.
    function automatic logic [TRAP_CNT_W-1:0] sat_inc(input logic [TRAP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/clken_div.sv
// Runtime-programmable clock-enable divider. The ratio is reloaded only at a
// period boundary (or while held), so changing div mid-period never shortens
// the period in progress. clk_en is registered and is high during the clock in
// which the counter sits at N-1.
module clken_div
    import sysctrl_pkg::*;
#(
    parameter int CLKDIV = 6,
    parameter int DIVW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic [DIVW-1:0] div,
    output logic            clk_en
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] n_lat;
    logic [DIVW-1:0] n_eff;
    logic [DIVW-1:0] cnt_inc;
    logic            wrap;

    // Effective ratio for the next period and end-of-period detection.
    always_comb begin
        n_eff   = (div == '0) ? DIVW'(CLKDIV) : div;
        wrap    = (cnt == n_lat - DIVW'(1));
        cnt_inc = cnt + DIVW'(1);
    end

    // Counter, latched ratio and the look-ahead registered enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            n_lat  <= DIVW'(CLKDIV);
            clk_en <= 1'b0;
        end else if (hold) begin
            cnt    <= '0;
            n_lat  <= n_eff;
            clk_en <= 1'b0;
        end else if (wrap) begin
            cnt    <= '0;
            n_lat  <= n_eff;
            clk_en <= (n_eff == DIVW'(1));
        end else begin
            cnt    <= cnt_inc;
            clk_en <= (cnt_inc == n_lat - DIVW'(1));
        end
    end

endmodule

// File: rtl/sysctrl.sv
// Board-level system controller: clock-enable divider, debounced reset
// button, stretched synchronous system reset and a trap supervisor that
// either halts the core or restarts it through the RESET state.
module sysctrl
    import sysctrl_pkg::*;
#(
    parameter int CLKDIV          = 6,
    parameter int DIVW            = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RESET_CYCLES    = 16,
    parameter int TRAP_MODE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_n,
    input  logic                  trap,
    input  logic [DIVW-1:0]       div,
    output logic                  clk_en,
    output logic                  sys_reset,
    output logic [1:0]            state,
    output logic [TRAP_CNT_W-1:0] trap_count
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PCW = $clog2(RESET_CYCLES + 1);

    logic           btn_s1;
    logic           btn_s2;
    logic           btn_level;
    logic [DBW-1:0] db_cnt;
    logic           press;

    logic [1:0]     state_next;
    logic [PCW-1:0] pulse_cnt;
    logic [PCW-1:0] pulse_next;
    logic           trap_taken;
    logic           hold;

    // Two-flop synchroniser; idles at 1 (button released).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce: accept a new level after it differs from the accepted one for
    // DEBOUNCE_CYCLES consecutive clocks; a return to the old level restarts
    // the count. An accepted fall emits a one-clock press pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_level <= 1'b1;
            db_cnt    <= '0;
            press     <= 1'b0;
        end else if (btn_s2 != btn_level) begin
            if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                btn_level <= btn_s2;
                db_cnt    <= '0;
                press     <= ~btn_s2;
            end else begin
                db_cnt    <= db_cnt + 1'b1;
                press     <= 1'b0;
            end
        end else begin
            db_cnt <= '0;
            press  <= 1'b0;
        end
    end

    // Next-state logic; a press overrides every other transition.
    always_comb begin
        trap_taken = (state == ST_RUN) && clk_en && trap;
        state_next = state;
        case (state)
            ST_RESET: if (clk_en && pulse_cnt == PCW'(RESET_CYCLES - 1)) state_next = ST_RUN;
            ST_RUN:   if (trap_taken) state_next = (TRAP_MODE == TRAP_MODE_RESTART) ? ST_RESET : ST_HALT;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_RESET;
        endcase
        if (press) state_next = ST_RESET;

        if (state != ST_RESET || state_next != ST_RESET || press) pulse_next = '0;
        else if (clk_en) pulse_next = pulse_cnt + 1'b1;
        else pulse_next = pulse_cnt;

        // Hold on the next state so no enable escapes on the edge entering HALT.
        hold = (state_next == ST_HALT);
    end

    clken_div #(
        .CLKDIV (CLKDIV),
        .DIVW   (DIVW)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .hold   (hold),
        .div    (div),
        .clk_en (clk_en)
    );

    // FSM state, reset-stretch pulse counter, registered reset and trap count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RESET;
            pulse_cnt  <= '0;
            sys_reset  <= 1'b1;
            trap_count <= '0;
        end else begin
            state     <= state_next;
            pulse_cnt <= pulse_next;
            sys_reset <= (state_next == ST_RESET);
            if (trap_taken) trap_count <= sat_inc(trap_count);
        end
    end

endmodule

// File: tb/tb_sysctrl.sv
// Bench for sysctrl: two instances (halt mode and auto-restart mode) run side
// by side against a cycle-level behavioural model, plus table-driven and
// hand-written sequences for divider reloads, debounce and trap handling.
module tb_sysctrl;
    import sysctrl_pkg::*;

    localparam int CLKDIV = 6;
    localparam int DIVW   = 8;
    localparam int DB     = 8;
    localparam int RC     = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       btn_n0 = 1'b1, trap0 = 1'b0;
    logic       btn_n1 = 1'b1, trap1 = 1'b0;
    logic [7:0] div0 = '0, div1 = '0;
    logic       clk_en0, sys_reset0, clk_en1, sys_reset1;
    logic [1:0] state0, state1;
    logic [7:0] trap_count0, trap_count1;

    int vectors     = 0;
    int miscompares = 0;
    int tk          = 0;

    always #5 clk = ~clk;

    sysctrl #(.CLKDIV(CLKDIV), .DIVW(DIVW), .DEBOUNCE_CYCLES(DB), .RESET_CYCLES(RC), .TRAP_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .btn_n(btn_n0), .trap(trap0), .div(div0),
        .clk_en(clk_en0), .sys_reset(sys_reset0), .state(state0), .trap_count(trap_count0));

    sysctrl #(.CLKDIV(CLKDIV), .DIVW(DIVW), .DEBOUNCE_CYCLES(DB), .RESET_CYCLES(RC), .TRAP_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .btn_n(btn_n1), .trap(trap1), .div(div1),
        .clk_en(clk_en1), .sys_reset(sys_reset1), .state(state1), .trap_count(trap_count1));

    // Behavioural model: absolute cycle numbers for divider periods, pulses
    // remaining for the reset stretch, run length for the debouncer.
    typedef struct packed {
        int cyc; int start; int n; bit en;
        int st; int left; int traps; bit srst;
        bit b1; bit b2; bit level; int run; bit press; int mode;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t m_reset(input int mode);
        mdl_t m;
        m.cyc = 1; m.start = 1; m.n = CLKDIV; m.en = 1'b0;
        m.st = 0; m.left = RC; m.traps = 0; m.srst = 1'b1;
        m.b1 = 1'b1; m.b2 = 1'b1; m.level = 1'b1; m.run = 0; m.press = 1'b0;
        m.mode = mode;
        return m;
    endfunction

    function automatic mdl_t m_step(input mdl_t m, input bit btn, input bit trp, input int dv);
        mdl_t r;
        bit   taken;
        int   eff;
        r = m;
        taken = (m.st == 1) && m.en && trp;
        if (taken && r.traps < 255) r.traps = r.traps + 1;
        if (m.press) begin
            r.st = 0; r.left = RC;
        end else if (m.st == 0) begin
            if (m.en) begin
                r.left = r.left - 1;
                if (r.left == 0) r.st = 1;
            end
        end else if (taken) begin
            r.st = (m.mode == 1) ? 0 : 2;
            r.left = RC;
        end
        r.srst = (r.st == 0);
        eff = (dv == 0) ? CLKDIV : dv;
        if (r.st == 2 || m.cyc == m.start + m.n - 1) begin
            r.start = m.cyc + 1;
            r.n = eff;
        end
        r.cyc = m.cyc + 1;
        r.en = (r.st != 2) && (r.cyc == r.start + r.n - 1);
        r.press = 1'b0;
        if (m.b2 != m.level) begin
            r.run = m.run + 1;
            if (r.run == DB) begin
                r.level = m.b2; r.run = 0; r.press = !m.b2;
            end
        end else begin
            r.run = 0;
        end
        r.b2 = m.b1;
        r.b1 = btn;
        return r;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, got, exp, tk);
        end
    endtask

    task automatic check_model();
        vectors++;
        if (clk_en0 !== m0.en || sys_reset0 !== m0.srst || int'(state0) != m0.st || int'(trap_count0) != m0.traps) begin
            miscompares++;
            $display("FAIL model dut0 tick %0d: got en=%b rst=%b st=%0d tc=%0d, expected en=%b rst=%b st=%0d tc=%0d",
                     tk, clk_en0, sys_reset0, state0, trap_count0, m0.en, m0.srst, m0.st, m0.traps);
        end
        vectors++;
        if (clk_en1 !== m1.en || sys_reset1 !== m1.srst || int'(state1) != m1.st || int'(trap_count1) != m1.traps) begin
            miscompares++;
            $display("FAIL model dut1 tick %0d: got en=%b rst=%b st=%0d tc=%0d, expected en=%b rst=%b st=%0d tc=%0d",
                     tk, clk_en1, sys_reset1, state1, trap_count1, m1.en, m1.srst, m1.st, m1.traps);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // sample the DUTs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            m0 = m_step(m0, btn_n0, trap0, int'(div0));
            m1 = m_step(m1, btn_n1, trap1, int'(div1));
        end
        tk++;
        #1;
        check_model();
    endtask

    task automatic wait_en0(output int t);
        t = -1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (clk_en0) begin
                t = tk;
                break;
            end
        end
    endtask

    task automatic wait_state(input int d, input int v, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (int'(d == 0 ? state0 : state1) == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct { int dv; int gap1; int gap2; } dv_t;
    typedef struct { int low; int rise; int hold; } bt_t;

    dv_t dtab[6];
    bt_t btab[5];

    initial begin
        int  first_en, n_en, fall, st_fall;
        int  t0, t1, t2, rise, hcnt, en_cnt, halt_cnt, restarts, tc_before;
        bit  ok, saw_reset;
        int  bl0, bl1;

        dtab[0] = '{3, 6, 3};
        dtab[1] = '{1, 3, 1};
        dtab[2] = '{0, 1, 6};
        dtab[3] = '{5, 6, 5};
        dtab[4] = '{2, 5, 2};
        dtab[5] = '{7, 2, 7};
        btab[0] = '{3, 0, 0};
        btab[1] = '{5, 0, 0};
        btab[2] = '{7, 0, 0};
        btab[3] = '{8, 11, 16};
        btab[4] = '{20, 11, 16};

        // Power-on reset.
        #1 reset = 1'b1;
        m0 = m_reset(0);
        m1 = m_reset(1);
        #1;
        check("por_state", int'(state0), 0);
        check("por_sys_reset", int'(sys_reset0), 1);
        check("por_clk_en", int'(clk_en0), 0);
        check("por_trap_count", int'(trap_count1), 0);
        repeat (3) tick();
        reset = 1'b0;

        // Release: enables every 6th clock, sys_reset falls in clock 97.
        first_en = -1; n_en = 0; fall = -1; st_fall = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (clk_en0 && first_en < 0) first_en = k + 1;
            if (clk_en0 && k + 1 <= 96) n_en++;
            if (!sys_reset0 && fall < 0) begin
                fall = k + 1;
                st_fall = int'(state0);
            end
        end
        check("release_first_en_clock", first_en, 6);
        check("release_pulse_count", n_en, 16);
        check("release_sys_reset_fall_clock", fall, 97);
        check("release_state_run", st_fall, 1);

        // Divider reload table: old period completes, then the new ratio.
        for (int i = 0; i < 6; i++) begin
            wait_en0(t0);
            tick();
            div0 = 8'(dtab[i].dv);
            if (clk_en0) t1 = tk;
            else wait_en0(t1);
            wait_en0(t2);
            check($sformatf("div%0d_first_gap", dtab[i].dv), t1 - t0, dtab[i].gap1);
            check($sformatf("div%0d_gap", dtab[i].dv), t2 - t1, dtab[i].gap2);
        end

        // Debounce table: glitches ignored, real presses reset 11 clocks later.
        div0 = 8'd1;
        div1 = 8'd1;
        repeat (10) tick();
        for (int i = 0; i < 5; i++) begin
            wait_state(0, 1, 100, ok);
            repeat (12) tick();
            check($sformatf("btn%0d_in_run", btab[i].low), int'(state0), 1);
            btn_n0 = 1'b0;
            rise = 0; hcnt = 0;
            for (int k = 1; k <= 60; k++) begin
                tick();
                if (k == btab[i].low) btn_n0 = 1'b1;
                if (sys_reset0) begin
                    if (rise == 0) rise = k;
                    hcnt++;
                end
            end
            check($sformatf("btn%0d_rise", btab[i].low), rise, btab[i].rise);
            check($sformatf("btn%0d_hold", btab[i].low), hcnt, btab[i].hold);
        end

        // Halt mode: trap freezes the enable, a press restarts.
        div0 = 8'd0;
        wait_state(0, 1, 100, ok);
        repeat (12) tick();
        trap0 = 1'b1;
        wait_state(0, 2, 20, ok);
        check("halt_reached", int'(ok), 1);
        check("halt_trap_count", int'(trap_count0), 1);
        en_cnt = 0; halt_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (clk_en0) en_cnt++;
            if (state0 == 2'd2) halt_cnt++;
        end
        check("halt_no_clk_en", en_cnt, 0);
        check("halt_stays", halt_cnt, 20);
        trap0 = 1'b0;
        btn_n0 = 1'b0;
        saw_reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (state0 == 2'd0) saw_reset = 1'b1;
        end
        btn_n0 = 1'b1;
        check("halt_press_to_reset", int'(saw_reset), 1);
        wait_state(0, 1, 200, ok);
        check("halt_press_back_to_run", int'(ok), 1);
        check("halt_trap_count_kept", int'(trap_count0), 1);

        // Restart mode: trap coinciding with a press is still counted.
        trap1 = 1'b1;
        wait_state(1, 1, 60, ok);
        repeat (7) tick();
        btn_n1 = 1'b0;
        tc_before = int'(trap_count1);
        repeat (10) tick();
        check("coinc_run_before", int'(state1), 1);
        tick();
        check("coinc_state_reset", int'(state1), 0);
        check("coinc_trap_counted", int'(trap_count1), tc_before + 1);
        tick();
        btn_n1 = 1'b1;

        // 300 auto-restarts; the count saturates at 255.
        restarts = 0;
        for (int k = 0; k < 300 * 24 && restarts < 300; k++) begin
            tick();
            if (state1 == 2'd1) restarts++;
        end
        tick();
        check("restart_count", restarts, 300);
        check("restart_trap_count_sat", int'(trap_count1), 255);
        check("restart_state_reset", int'(state1), 0);
        trap1 = 1'b0;

        // Randomised traffic on both instances against the model.
        bl0 = 0; bl1 = 0;
        for (int k = 0; k < 3000 && miscompares < 20; k++) begin
            trap0 = ($urandom_range(0, 3) == 0);
            trap1 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) div0 = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) div1 = 8'($urandom_range(0, 7));
            if (bl0 == 0 && $urandom_range(0, 99) == 0) bl0 = $urandom_range(1, 24);
            if (bl1 == 0 && $urandom_range(0, 99) == 0) bl1 = $urandom_range(1, 24);
            btn_n0 = (bl0 == 0);
            btn_n1 = (bl1 == 0);
            if (bl0 > 0) bl0--;
            if (bl1 > 0) bl1--;
            tick();
        end

        // Asynchronous reset between edges while running.
        trap0 = 1'b0; trap1 = 1'b0; btn_n1 = 1'b1;
        div0 = 8'd1;
        btn_n0 = 1'b0;
        repeat (12) tick();
        btn_n0 = 1'b1;
        wait_state(0, 1, 300, ok);
        repeat (12) tick();
        check("async_pre_run", int'(state0), 1);
        check("async_pre_clk_en", int'(clk_en0), 1);
        check("async_pre_trap_count_nz", int'(trap_count0 != 0), 1);
        #2 reset = 1'b1;
        m0 = m_reset(0);
        m1 = m_reset(1);
        #1;
        check("async_sys_reset", int'(sys_reset0), 1);
        check("async_clk_en", int'(clk_en0), 0);
        check("async_state", int'(state0), 0);
        check("async_trap_count", int'(trap_count0), 0);
        tick();
        reset = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
